avalon_mem_responder: RTL

//  Avalon-MM slave (responder) backed by an on-chip 32-bit word RAM; answers a master using active-low read_n/write_n/byteenable_n.

---
 rtl/avalon_mem_responder_if.sv | 24 ++
 rtl/avalon_mem_responder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/avalon_mem_responder_if.sv
// rtl/avalon_mem_responder_if.sv - Avalon-MM bus bundle between a master and the memory responder
interface avalon_mem_responder_if;
  logic [23:0] avalon_address;
  logic [3:0]  avalon_byteenable_n;
  logic        avalon_chipselect;
  logic [31:0] avalon_writedata;
  logic        avalon_read_n;
  logic        avalon_write_n;
  logic [31:0] avalon_readdata;
  logic        avalon_readdatavalid;
  logic        avalon_waitrequest;

  modport master (
    output avalon_address, avalon_byteenable_n, avalon_chipselect, avalon_writedata,
           avalon_read_n, avalon_write_n,
    input  avalon_readdata, avalon_readdatavalid, avalon_waitrequest
  );

  modport slave (
    input  avalon_address, avalon_byteenable_n, avalon_chipselect, avalon_writedata,
           avalon_read_n, avalon_write_n,
    output avalon_readdata, avalon_readdatavalid, avalon_waitrequest
  );
endinterface

// File: rtl/avalon_mem_responder.sv
// rtl/avalon_mem_responder.sv - Avalon-MM word RAM responder with clear sequence and pipelined reads
module avalon_mem_responder #(
  parameter int          P_ADDR_NBIT = 8,
  parameter int          P_RD_LAT    = 2,
  parameter logic [31:0] P_INIT_VAL  = 32'h00000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  avalon_mem_responder_if.slave  bus,
  input  logic                   mem_clear,
  output logic                   init_done,
  output logic                   proto_err
);
  localparam int DEPTH = 1 << P_ADDR_NBIT;

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t                 state_q, state_d;
  logic [P_ADDR_NBIT-1:0] cnt_q, cnt_d;
  logic                   waitrequest_q, waitrequest_d;
  logic                   init_done_q, init_done_d;
  logic                   proto_err_q, proto_err_d;
  logic [P_RD_LAT-1:0]    rd_vld_q, rd_vld_d;
  logic [31:0]            rd_data_q [P_RD_LAT];
  logic [31:0]            rd_data_d [P_RD_LAT];

  logic [31:0]            mem_q [DEPTH];

  logic [P_ADDR_NBIT-1:0] addr_idx;
  logic                   rd_acc, wr_acc, both_req;
  logic                   ram_we;
  logic [P_ADDR_NBIT-1:0] ram_waddr;
  logic [31:0]            ram_wdata;
  logic [3:0]             ram_wbe;
  logic                   unused_addr_bits;

  // Upper address bits alias onto the implemented depth.
  assign addr_idx         = bus.avalon_address[P_ADDR_NBIT-1:0];
  assign unused_addr_bits = ^bus.avalon_address[23:P_ADDR_NBIT];

  assign rd_acc   = bus.avalon_chipselect & ~bus.avalon_read_n & bus.avalon_write_n & ~waitrequest_q;
  assign wr_acc   = bus.avalon_chipselect & ~bus.avalon_write_n & bus.avalon_read_n & ~waitrequest_q;
  assign both_req = bus.avalon_chipselect & ~bus.avalon_read_n & ~bus.avalon_write_n;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    waitrequest_d = waitrequest_q;
    init_done_d   = init_done_q;
    proto_err_d   = proto_err_q | both_req;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {P_ADDR_NBIT{1'b1}}) begin
          state_d       = ST_IDLE;
          waitrequest_d = 1'b0;
          init_done_d   = 1'b1;
        end
      end
      default: ;
    endcase
    // A clear request overrides everything and restarts the sweep from word 0.
    if (mem_clear) begin
      state_d       = ST_INIT;
      cnt_d         = '0;
      waitrequest_d = 1'b1;
      init_done_d   = 1'b0;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = addr_idx;
    ram_wdata = bus.avalon_writedata;
    ram_wbe   = ~bus.avalon_byteenable_n;
    if (state_q == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_q;
      ram_wdata = P_INIT_VAL;
      ram_wbe   = 4'hF;
    end else if (wr_acc) begin
      ram_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_wbe[i]) mem_q[ram_waddr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  // Data in each stage only advances alongside a valid, so the output holds its last value.
  always_comb begin
    rd_vld_d     = '0;
    rd_vld_d[0]  = rd_acc;
    rd_data_d[0] = rd_acc ? mem_q[addr_idx] : rd_data_q[0];
    for (int i = 1; i < P_RD_LAT; i++) begin
      rd_vld_d[i]  = rd_vld_q[i-1];
      rd_data_d[i] = rd_vld_q[i-1] ? rd_data_q[i-1] : rd_data_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      waitrequest_q <= 1'b1;
      init_done_q   <= 1'b0;
      proto_err_q   <= 1'b0;
      rd_vld_q      <= '0;
      for (int i = 0; i < P_RD_LAT; i++) rd_data_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      waitrequest_q <= waitrequest_d;
      init_done_q   <= init_done_d;
      proto_err_q   <= proto_err_d;
      rd_vld_q      <= rd_vld_d;
      for (int i = 0; i < P_RD_LAT; i++) rd_data_q[i] <= rd_data_d[i];
    end
  end

  assign bus.avalon_readdata      = rd_data_q[P_RD_LAT-1];
  assign bus.avalon_readdatavalid = rd_vld_q[P_RD_LAT-1];
  assign bus.avalon_waitrequest   = waitrequest_q;
  assign init_done                = init_done_q;
  assign proto_err                = proto_err_q;
endmodule
